// File: rtl/mem_bus_arbiter.sv
// Shares the single memory bus between the IF and MEM pipeline stages. MEM has fixed priority.
// Optional grant watchdog: define BUS_ARB_TIMEOUT_EN to abort grants that wait TIMEOUT_CYCLES without bus_ack.
module mem_bus_arbiter #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ack,
  input  logic        mem_req,
  input  logic        mem_we,
  input  logic [3:0]  mem_be,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  output logic        mem_ack,
  output logic        bus_req,
  output logic        bus_we,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack,
  output logic        stall_req,
  output logic        timeout_err
);

  typedef enum logic [1:0] {IDLE, GNT_MEM, GNT_IF} state_t;

  state_t state, state_nxt;
  logic   abort;
  logic   done;

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("mem_bus_arbiter: TIMEOUT_CYCLES must be within 1..255");
  end

`ifdef BUS_ARB_TIMEOUT_EN
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0] tmo_cnt;

  // Held at zero while idle, so every grant starts counting from zero.
  always_ff @(posedge clk) begin
    if (rst)                 tmo_cnt <= '0;
    else if (state == IDLE)  tmo_cnt <= '0;
    else if (!bus_ack)       tmo_cnt <= tmo_cnt + 8'd1;
  end

  assign abort = (state != IDLE) && !bus_ack && (tmo_cnt == TMO_LAST) && !rst;
`else
  assign abort = 1'b0;
`endif

  assign timeout_err = abort;
  // A reset in the same cycle as bus_ack suppresses the completion.
  assign done        = (state != IDLE) && (bus_ack || abort) && !rst;
  assign bus_req     = (state != IDLE);
  assign stall_req   = (if_req & ~if_ack) | (mem_req & ~mem_ack);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    if_ack    = 1'b0;
    if_rdata  = '0;
    mem_ack   = 1'b0;
    mem_rdata = '0;
    unique case (state)
      IDLE: begin
        if (mem_req)     state_nxt = GNT_MEM;
        else if (if_req) state_nxt = GNT_IF;
      end
      GNT_MEM: begin
        if (done) begin
          mem_ack   = 1'b1;
          mem_rdata = bus_ack ? bus_rdata : '0;
          state_nxt = IDLE;
        end
      end
      GNT_IF: begin
        if (done) begin
          if_ack    = 1'b1;
          if_rdata  = bus_ack ? bus_rdata : '0;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Transaction fields are captured only at arbitration and held for the whole grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus_we    <= 1'b0;
      bus_be    <= '0;
      bus_addr  <= '0;
      bus_wdata <= '0;
    end else if (state == IDLE) begin
      if (mem_req) begin
        bus_we    <= mem_we;
        bus_be    <= mem_be;
        bus_addr  <= mem_addr;
        bus_wdata <= mem_wdata;
      end else if (if_req) begin
        bus_we    <= 1'b0;
        bus_be    <= 4'b1111;
        bus_addr  <= if_addr;
        bus_wdata <= '0;
      end
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: inputs change 1ns after each rising edge, outputs are checked 1ns later.
// Covers the timeout path when BUS_ARB_TIMEOUT_EN is defined, the indefinite wait otherwise.
module tb_mem_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ack;
  logic        mem_req;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic        bus_req;
  logic        bus_we;
  logic [3:0]  bus_be;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_ack;
  logic        stall_req;
  logic        timeout_err;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_bus_arbiter #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
    .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .bus_req(bus_req), .bus_we(bus_we), .bus_be(bus_be), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ack(bus_ack),
    .stall_req(stall_req), .timeout_err(timeout_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    rst = 1'b1; if_req = 1'b0; if_addr = '0;
    mem_req = 1'b0; mem_we = 1'b0; mem_be = '0; mem_addr = '0; mem_wdata = '0;
    bus_ack = 1'b0; bus_rdata = '0;
    cyc(); cyc();
    rst = 1'b0;
    settle();
    check("rst_bus_req",   bus_req,     0);
    check("rst_bus_we",    bus_we,      0);
    check("rst_bus_be",    bus_be,      0);
    check("rst_bus_addr",  bus_addr,    0);
    check("rst_bus_wdata", bus_wdata,   0);
    check("rst_if_ack",    if_ack,      0);
    check("rst_mem_ack",   mem_ack,     0);
    check("rst_stall",     stall_req,   0);
    check("rst_tmo",       timeout_err, 0);

    // Zero-wait IF fetch
    cyc();
    if_req = 1'b1; if_addr = 32'h0000_0040;
    settle();
    check("if0_stall",   stall_req, 1);
    check("if0_bus_req", bus_req,   0);
    cyc();
    bus_ack = 1'b1; bus_rdata = 32'h2408_0001;
    settle();
    check("if1_bus_req", bus_req,  1);
    check("if1_bus_be",  bus_be,   32'hF);
    check("if1_bus_we",  bus_we,   0);
    check("if1_addr",    bus_addr, 32'h0000_0040);
    check("if1_ack",     if_ack,   1);
    check("if1_rdata",   if_rdata, 32'h2408_0001);
    check("if1_mem_ack", mem_ack,  0);
    check("if1_stall",   stall_req, 0);
    cyc();
    if_req = 1'b0; bus_ack = 1'b0; bus_rdata = '0;
    settle();
    check("if2_bus_req", bus_req, 0);
    check("if2_ack",     if_ack,  0);

    // Simultaneous IF and MEM requests: MEM first
    cyc();
    if_req = 1'b1; if_addr = 32'h0000_0044;
    mem_req = 1'b1; mem_we = 1'b1; mem_be = 4'b0011;
    mem_addr = 32'h8000_0010; mem_wdata = 32'hDEAD_BEEF;
    settle();
    check("sim0_stall", stall_req, 1);
    cyc();
    settle();
    check("sim1_bus_req", bus_req,   1);
    check("sim1_we",      bus_we,    1);
    check("sim1_be",      bus_be,    32'h3);
    check("sim1_addr",    bus_addr,  32'h8000_0010);
    check("sim1_wdata",   bus_wdata, 32'hDEAD_BEEF);
    check("sim1_mem_ack", mem_ack,   0);
    cyc();
    bus_ack = 1'b1;
    settle();
    check("sim2_mem_ack", mem_ack,   1);
    check("sim2_if_ack",  if_ack,    0);
    check("sim2_if_rd",   if_rdata,  0);
    check("sim2_stall",   stall_req, 1);
    cyc();
    mem_req = 1'b0; mem_we = 1'b0; bus_ack = 1'b0;
    settle();
    check("sim3_bus_req", bus_req,   0);
    check("sim3_if_ack",  if_ack,    0);
    check("sim3_stall",   stall_req, 1);
    cyc();
    bus_ack = 1'b1; bus_rdata = 32'hAAAA_5555;
    settle();
    check("sim4_bus_req", bus_req,   1);
    check("sim4_addr",    bus_addr,  32'h0000_0044);
    check("sim4_be",      bus_be,    32'hF);
    check("sim4_we",      bus_we,    0);
    check("sim4_wdata",   bus_wdata, 0);
    check("sim4_if_ack",  if_ack,    1);
    check("sim4_if_rd",   if_rdata,  32'hAAAA_5555);
    check("sim4_mem_ack", mem_ack,   0);
    check("sim4_stall",   stall_req, 0);
    cyc();
    if_req = 1'b0; bus_ack = 1'b0; bus_rdata = '0;
    settle();
    check("sim5_bus_req", bus_req, 0);

    // MEM read with three wait states, acked in the fourth grant cycle
    cyc();
    mem_req = 1'b1; mem_we = 1'b0; mem_be = 4'hF; mem_addr = 32'h0000_0100; mem_wdata = 32'h0;
    cyc();
    for (int i = 0; i < 3; i++) begin
      settle();
      check("ws_bus_req", bus_req,   1);
      check("ws_addr",    bus_addr,  32'h0000_0100);
      check("ws_be",      bus_be,    32'hF);
      check("ws_we",      bus_we,    0);
      check("ws_mem_ack", mem_ack,   0);
      check("ws_stall",   stall_req, 1);
      check("ws_tmo",     timeout_err, 0);
      cyc();
    end
    bus_ack = 1'b1; bus_rdata = 32'h1234_5678;
    settle();
    check("ws_ack",       mem_ack,     1);
    check("ws_rdata",     mem_rdata,   32'h1234_5678);
    check("ws_ack_tmo",   timeout_err, 0);
    check("ws_ack_stall", stall_req,   0);
    cyc();
    mem_req = 1'b0; bus_ack = 1'b0; bus_rdata = '0;
    settle();
    check("ws_ack_drop", mem_ack, 0);
    check("ws_req_drop", bus_req, 0);

    // Reset during the second GNT_IF cycle, coincident with bus_ack
    cyc();
    if_req = 1'b1; if_addr = 32'h0000_0080;
    cyc();
    settle();
    check("rg1_bus_req", bus_req, 1);
    check("rg1_if_ack",  if_ack,  0);
    cyc();
    rst = 1'b1; bus_ack = 1'b1; bus_rdata = 32'h5555_AAAA;
    settle();
    check("rg2_if_ack", if_ack,   0);
    check("rg2_if_rd",  if_rdata, 0);
    cyc();
    rst = 1'b0; if_req = 1'b0; bus_ack = 1'b0; bus_rdata = '0;
    settle();
    check("rg3_bus_req", bus_req,   0);
    check("rg3_addr",    bus_addr,  0);
    check("rg3_be",      bus_be,    0);
    check("rg3_if_ack",  if_ack,    0);
    check("rg3_mem_ack", mem_ack,   0);
    check("rg3_stall",   stall_req, 0);
    cyc();
    settle();
    check("rg4_bus_req", bus_req, 0);

`ifdef BUS_ARB_TIMEOUT_EN
    // Slave never acks: abort in the fourth grant cycle
    cyc();
    mem_req = 1'b1; mem_we = 1'b0; mem_be = 4'hF; mem_addr = 32'h0000_0200;
    bus_rdata = 32'hFFFF_FFFF;
    cyc();
    for (int i = 0; i < 3; i++) begin
      settle();
      check("to_wait_ack", mem_ack,     0);
      check("to_wait_err", timeout_err, 0);
      check("to_wait_req", bus_req,     1);
      cyc();
    end
    settle();
    check("to_ack",   mem_ack,     1);
    check("to_rdata", mem_rdata,   0);
    check("to_err",   timeout_err, 1);
    check("to_if",    if_ack,      0);
    cyc();
    mem_req = 1'b0; bus_rdata = '0;
    settle();
    check("to_after_req", bus_req,     0);
    check("to_after_err", timeout_err, 0);
`else
    // Without the watchdog a grant waits for bus_ack indefinitely
    cyc();
    mem_req = 1'b1; mem_we = 1'b0; mem_be = 4'hF; mem_addr = 32'h0000_0200;
    cyc();
    for (int i = 0; i < 120; i++) begin
      settle();
      check("nt_req", bus_req,     1);
      check("nt_err", timeout_err, 0);
      check("nt_ack", mem_ack,     0);
      cyc();
    end
    bus_ack = 1'b1; bus_rdata = 32'h0BAD_F00D;
    settle();
    check("nt_final_ack",   mem_ack,   1);
    check("nt_final_rdata", mem_rdata, 32'h0BAD_F00D);
    cyc();
    mem_req = 1'b0; bus_ack = 1'b0; bus_rdata = '0;
    settle();
    check("nt_after_req", bus_req, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
